countermod_n: RTL

//   Parametrised modulo-N up/down counter. Successor to the fixed mod-4 counter.

---
 rtl/countermod_n.sv | 88 ++++++++
 1 files changed

// File: rtl/countermod_n.sv
// Modulo-MODULUS up/down counter with enable, clear, load and one-shot stop; tc flag is combinational.
// Latency: value/wrap/done register on the edge after sampling, tc zero latency; no backpressure.
module countermod_n #(
  parameter int MODULUS     = 10,
  parameter int RESET_VALUE = 0,
  localparam int WIDTH      = (MODULUS > 1) ? $clog2(MODULUS) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             up,
  input  logic             one_shot,
  output logic [WIDTH-1:0] value,
  output logic             tc,
  output logic             wrap,
  output logic             done
);

  localparam logic [0:0]       RUN     = 1'b0;
  localparam logic [0:0]       DONE    = 1'b1;
  localparam logic [WIDTH-1:0] MAX     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [WIDTH-1:0] value_nxt;
  logic             wrap_nxt;
  logic             at_top;
  logic             at_bot;
  logic [WIDTH-1:0] load_sat;
  logic [WIDTH-1:0] step_val;

  assign at_top = (value == MAX);
  assign at_bot = (value == '0);
  assign tc     = up ? at_top : at_bot;

  // Out-of-range loads clamp to the top of the range rather than aliasing.
  assign load_sat = ({1'b0, load_value} >= MOD_EXT) ? MAX : load_value;

  // Explicit terminal compares keep non-power-of-2 moduli inside 0..MODULUS-1.
  always_comb begin
    step_val = value;
    if (up) begin
      step_val = at_top ? '0 : value + WIDTH'(1);
    end else begin
      step_val = at_bot ? MAX : value - WIDTH'(1);
    end
  end

  always_comb begin
    value_nxt = value;
    state_nxt = state;
    wrap_nxt  = 1'b0;
    if (clear) begin
      value_nxt = RST_VAL;
      state_nxt = RUN;
    end else if (load) begin
      value_nxt = load_sat;
      state_nxt = RUN;
    end else if (enable && (state == RUN)) begin
      if (tc && one_shot) begin
        state_nxt = DONE;
      end else begin
        value_nxt = step_val;
        wrap_nxt  = tc;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value <= RST_VAL;
      state <= RUN;
      wrap  <= 1'b0;
    end else begin
      value <= value_nxt;
      state <= state_nxt;
      wrap  <= wrap_nxt;
    end
  end

  assign done = (state == DONE);

endmodule
